imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares the single-port instruction memory between the CPU fetch unit and the
//  boot/debug loader. Holds the CPU in a BOOT phase after reset while the loader
//  writes the program image, then arbitrates fetch reads against loader accesses.
//  Sits between the fetch stage/loader and the synchronous instruction memory.
// PARAMETERS
//  ADDR_W        16  word-address bits driven to memory (byte addr bits [ADDR_W+1:2])
//  DATA_W        32  instruction/data word width
//  MAX_LD_BURST  4   max consecutive loader grants while fetch waits (>=1)
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  rst_n         in   1       asynchronous active-low reset
//  f_req         in   1       fetch read request
//  f_addr        in   32      fetch byte address
//  f_gnt         out  1       fetch request accepted this cycle
//  f_rvalid      out  1       fetch read data valid
//  f_rdata       out  DATA_W  fetch read data
//  l_req         in   1       loader request
//  l_we          in   1       loader write (1) / read (0)
//  l_addr        in   32      loader byte address
//  l_wdata       in   DATA_W  loader write data
//  l_gnt         out  1       loader request accepted this cycle
//  l_rvalid      out  1       loader read data valid
//  l_rdata       out  DATA_W  loader read data
//  boot_done     in   1       loader pulse: image loaded, release CPU
//  cpu_stall     out  1       high while in BOOT
//  mem_en        out  1       memory access strobe
//  mem_we        out  1       memory write enable
//  mem_addr      out  ADDR_W  memory word address
//  mem_wdata     out  DATA_W  memory write data
//  mem_rdata     in   DATA_W  memory read data, valid 1 cycle after mem_en&!mem_we
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=BOOT, burst_cnt=0, rd_owner=NONE; all outputs 0
//    except cpu_stall=1. rst_n low mid-access drops any pending rvalid.
//  - FSM: BOOT -> RUN on boot_done=1 (sampled at clk edge); RUN -> BOOT only by reset.
//  - BOOT: f_gnt=0 always; l_gnt=l_req; fetch requests ignored (not queued).
//  - RUN: loader has priority; if loader granted while f_req=1, burst_cnt++;
//    when burst_cnt==MAX_LD_BURST and f_req=1, fetch wins that cycle, burst_cnt<=0.
//    burst_cnt<=0 whenever f_req=0 or fetch granted. Never both gnts in one cycle.
//  - gnt is combinational from req and registered state; the granted request drives
//    mem_en=1, mem_we=(loader&l_we), mem_addr=addr[ADDR_W+1:2], mem_wdata=l_wdata
//    the same cycle. addr bits above ADDR_W+1 ignored (wrap-around).
//  - Reads: rd_owner registered at grant; in grant cycle+1 exactly one of
//    f_rvalid/l_rvalid=1 with rdata=mem_rdata. Read latency 1, throughput 1/cycle.
//    Writes produce no rvalid. rdata outputs are 0 when rvalid=0.
//  - boot_done in same cycle as l_req: loader access completes, RUN from next cycle.
//  - A requester must hold req/addr/wdata stable until its gnt.
// CONFIGURATION
//  IMEM_ARB_ALIGN_CHECK_EN defined: a granted request with addr[1:0]!=0 does not
//    access memory (mem_en=0); next cycle the owner's rvalid=1 with rdata=0 plus
//    extra output err (1 bit, 1-cycle pulse) — applies to reads and writes.
//  Not defined: no err port; addr[1:0] ignored, access proceeds normally.
// TESTING
//  1 reset, f_req=1 addr 0x0, no boot_done -> f_gnt=0, cpu_stall=1, mem_en=0
//  2 BOOT: loader writes 0x2402000A to 0x8 then reads 0x8 -> mem_we=1 addr=2;
//    read l_rvalid=1 next cycle, l_rdata=0x2402000A
//  3 boot_done pulse, f_req addr 0x4 -> cpu_stall=0 next cycle, f_gnt=1, f_rvalid
//    one cycle later with mem word 1
//  4 RUN, l_req and f_req held 8 cycles, MAX_LD_BURST=4 -> grants L,L,L,L,F,L,L,L
//  5 rst_n=0 cycle after fetch grant -> f_rvalid stays 0, cpu_stall=1, state BOOT
//  6 ALIGN_CHECK_EN, f_addr=0x6 in RUN -> mem_en=0, next cycle f_rvalid=1, err=1

Source files
------------

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: holds the CPU in BOOT while the loader fills memory,
// then shares the port between fetch and loader. Option: IMEM_ARB_ALIGN_CHECK_EN.
module imem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int MAX_LD_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  input  logic              boot_done,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef IMEM_ARB_ALIGN_CHECK_EN
  ,
  output logic              err
`endif
);

  localparam int CNT_W = $clog2(MAX_LD_BURST + 1);

  typedef enum logic [0:0] {ST_BOOT, ST_RUN} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  owner_e             rd_owner_q, rd_owner_d;
  logic               rd_zero_q, rd_zero_d;

  logic [31:0]        sel_addr;
  logic               any_gnt;
  logic               misalign;
  logic               unused_addr_bits;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: RUN is only left through reset
  always_comb begin
    state_d = state_q;
    if (state_q == ST_BOOT && boot_done) begin
      state_d = ST_RUN;
    end
  end

  // Output logic: grants and stall
  always_comb begin
    f_gnt     = 1'b0;
    l_gnt     = 1'b0;
    cpu_stall = (state_q == ST_BOOT);
    if (rst_n) begin
      if (state_q == ST_BOOT) begin
        l_gnt = l_req;
      end else if (f_req && (burst_cnt_q >= CNT_W'(MAX_LD_BURST))) begin
        f_gnt = 1'b1;
      end else if (l_req) begin
        l_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
    end
  end

  // Count loader grants that made a waiting fetch lose
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q != ST_RUN || !f_req || f_gnt) begin
      burst_cnt_d = '0;
    end else if (l_gnt) begin
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end
  end

  assign any_gnt  = f_gnt | l_gnt;
  assign sel_addr = f_gnt ? f_addr : l_addr;

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  assign misalign = any_gnt & (|sel_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0],
                              l_addr[31:ADDR_W+2], l_addr[1:0]};

  always_comb begin
    mem_en    = any_gnt & ~misalign;
    mem_we    = any_gnt & ~misalign & l_gnt & l_we;
    mem_addr  = any_gnt ? sel_addr[ADDR_W+1:2] : '0;
    mem_wdata = (l_gnt & l_we) ? l_wdata : '0;
  end

  // A misaligned access of either kind still answers its owner, with zero data
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (f_gnt) begin
      rd_owner_d = OWN_FETCH;
    end else if (l_gnt && (!l_we || misalign)) begin
      rd_owner_d = OWN_LOAD;
    end
    rd_zero_d = misalign;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= '0;
      rd_owner_q  <= OWN_NONE;
      rd_zero_q   <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      rd_owner_q  <= rd_owner_d;
      rd_zero_q   <= rd_zero_d;
    end
  end

  always_comb begin
    f_rvalid = (rd_owner_q == OWN_FETCH);
    l_rvalid = (rd_owner_q == OWN_LOAD);
    f_rdata  = (f_rvalid && !rd_zero_q) ? mem_rdata : '0;
    l_rdata  = (l_rvalid && !rd_zero_q) ? mem_rdata : '0;
  end

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  assign err = rd_zero_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a small synchronous memory model.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, l_req, l_we, boot_done;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, l_gnt, l_rvalid, cpu_stall;
  logic [31:0] f_rdata, l_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
`ifdef IMEM_ARB_ALIGN_CHECK_EN
  logic        err;
`endif

  logic [31:0] mem_arr [0:255];
  int          errors = 0;
  int          checks = 0;
  bit          exp_f [8] = '{0, 0, 0, 0, 1, 0, 0, 0};

  imem_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_LD_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .boot_done(boot_done), .cpu_stall(cpu_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    rst_n = 1'b0; f_req = 1'b1; f_addr = 32'h0; l_req = 1'b1; l_we = 1'b0;
    l_addr = 32'h0; l_wdata = 32'h0; boot_done = 1'b0;

    // Reset state
    #2;
    chk("rst_cpu_stall", cpu_stall, 1);
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_l_gnt", l_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_f_rvalid", f_rvalid, 0);
    #10 rst_n = 1'b1;

    // BOOT ignores fetch
    tick(); l_req = 1'b0;
    @(negedge clk);
    chk("boot_f_gnt", f_gnt, 0);
    chk("boot_stall", cpu_stall, 1);
    chk("boot_mem_en", mem_en, 0);

    // Loader writes 0x2402000A to 0x8
    tick(); f_req = 1'b0; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h8; l_wdata = 32'h2402000A;
    @(negedge clk);
    chk("ldw_l_gnt", l_gnt, 1);
    chk("ldw_mem_we", mem_we, 1);
    chk("ldw_mem_addr", mem_addr, 2);
    chk("ldw_mem_wdata", mem_wdata, 32'h2402000A);
    chk("boot_no_f_rvalid", f_rvalid, 0);

    // Loader writes word 1
    tick(); l_addr = 32'h4; l_wdata = 32'h13579BDF;
    @(negedge clk);
    chk("ldw1_mem_addr", mem_addr, 1);
    chk("ldw_no_rvalid", l_rvalid, 0);

    // Loader reads 0x8 in the same cycle as boot_done
    tick(); l_we = 1'b0; l_addr = 32'h8; l_wdata = 32'h0; boot_done = 1'b1;
    @(negedge clk);
    chk("ldr_l_gnt", l_gnt, 1);
    chk("ldr_mem_we", mem_we, 0);
    chk("ldr_stall_still", cpu_stall, 1);

    // RUN: fetch 0x4
    tick(); l_req = 1'b0; boot_done = 1'b0; f_req = 1'b1; f_addr = 32'h4;
    @(negedge clk);
    chk("ldr_l_rvalid", l_rvalid, 1);
    chk("ldr_l_rdata", l_rdata, 32'h2402000A);
    chk("run_stall", cpu_stall, 0);
    chk("run_f_gnt", f_gnt, 1);
    chk("run_mem_addr", mem_addr, 1);

    tick(); f_req = 1'b0;
    @(negedge clk);
    chk("fetch_f_rvalid", f_rvalid, 1);
    chk("fetch_f_rdata", f_rdata, 32'h13579BDF);
    chk("fetch_l_rvalid", l_rvalid, 0);
    chk("idle_l_rdata", l_rdata, 0);

    // Burst limit: L,L,L,L,F,L,L,L
    for (int i = 0; i < 8; i++) begin
      tick(); f_req = 1'b1; f_addr = 32'h4; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h8;
      @(negedge clk);
      chk($sformatf("burst%0d_f_gnt", i), f_gnt, exp_f[i]);
      chk($sformatf("burst%0d_l_gnt", i), l_gnt, !exp_f[i]);
      if (i > 0) begin
        chk($sformatf("burst%0d_f_rvalid", i), f_rvalid, exp_f[i-1]);
        chk($sformatf("burst%0d_rdata", i), f_rdata | l_rdata,
            exp_f[i-1] ? 32'h13579BDF : 32'h2402000A);
      end
    end
    tick(); f_req = 1'b0; l_req = 1'b0;
    @(negedge clk);
    chk("burst_end_l_rvalid", l_rvalid, 1);
    chk("burst_end_l_rdata", l_rdata, 32'h2402000A);

    // Wrapped fetch address then reset one cycle after the grant
    tick(); f_req = 1'b1; f_addr = 32'h0004_0004;
    @(negedge clk);
    chk("wrap_f_gnt", f_gnt, 1);
    chk("wrap_mem_addr", mem_addr, 1);
    tick(); rst_n = 1'b0;
    #1;
    chk("rst_mid_f_rvalid", f_rvalid, 0);
    chk("rst_mid_stall", cpu_stall, 1);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rst_back_boot_f_gnt", f_gnt, 0);
    tick();
    @(negedge clk);
    chk("rst_back_f_rvalid", f_rvalid, 0);
    chk("rst_back_stall", cpu_stall, 1);

    // Back to RUN, fetch from misaligned 0x6
    tick(); f_req = 1'b0; boot_done = 1'b1;
    tick(); boot_done = 1'b0; f_req = 1'b1; f_addr = 32'h6;
    @(negedge clk);
    chk("mis_f_gnt", f_gnt, 1);
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    chk("mis_mem_en", mem_en, 0);
    tick(); f_req = 1'b0;
    @(negedge clk);
    chk("mis_f_rvalid", f_rvalid, 1);
    chk("mis_f_rdata", f_rdata, 0);
    chk("mis_err", err, 1);
    tick();
    @(negedge clk);
    chk("mis_err_clear", err, 0);
`else
    chk("mis_mem_en", mem_en, 1);
    chk("mis_mem_addr", mem_addr, 1);
    tick(); f_req = 1'b0;
    @(negedge clk);
    chk("mis_f_rvalid", f_rvalid, 1);
    chk("mis_f_rdata", f_rdata, 32'h13579BDF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
